pw_trigger_seq: RTL and testbench



---
 rtl/pw_trigger_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_pw_trigger_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_seq.sv
// pw_trigger_seq: trigger pulse-train sequencer for the front-end clock domain.
// A start (match & arm & enable while idle) latches the per-pulse delay/width
// tables and the pulse count, then plays out up to pNUM_TRIGGER_PULSES pulses.
// Optional feature macro: PW_TRIG_CAPTURE_DELAY_EN. When it is defined, a separate
// countdown times the capture-start pulse. Otherwise the capture pulse follows
// the start directly.
module pw_trigger_seq #(
   parameter int pNUM_TRIGGER_PULSES  = 8,
   parameter int pNUM_TRIGGER_WIDTH   = 4,
   parameter int pTRIG_CNT_WIDTH      = 24,
   parameter int pCAPTURE_DELAY_WIDTH = 18
) (
   input  logic                                           fe_clk,
   input  logic                                           reset_n,
   input  logic                                           arm_i,
   input  logic                                           trigger_enable_i,
   input  logic                                           match_i,
   input  logic [pTRIG_CNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] trigger_delay_i,
   input  logic [pTRIG_CNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] trigger_width_i,
   input  logic [pNUM_TRIGGER_WIDTH-1:0]                  num_triggers_i,
   input  logic [pCAPTURE_DELAY_WIDTH-1:0]                capture_delay_i,
   output logic                                           trigger_o,
   output logic                                           capture_enable_pulse_o,
   output logic                                           busy_o,
   output logic [pNUM_TRIGGER_WIDTH-1:0]                  pulse_index_o,
   output logic                                           done_pulse_o
);
   localparam int P  = pNUM_TRIGGER_PULSES;
   localparam int NW = pNUM_TRIGGER_WIDTH;
   localparam int CW = pTRIG_CNT_WIDTH;

   typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NW-1:0]    idx_q, idx_d, num_q, num_d;
   logic [CW*P-1:0]  dly_q, dly_d, wid_q, wid_d;
   logic             trigger_q, trigger_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cap_q, cap_d;
   logic             start, abort;
   logic [NW-1:0]    idx_inc;

   // Table lookup by pulse index; a plain loop keeps the index width independent of P.
   function automatic logic [CW-1:0] pick(input logic [CW*P-1:0] vec, input logic [NW-1:0] k);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < P; i++) begin
         if (int'(k) == i) r = vec[i*CW +: CW];
      end
      return r;
   endfunction

   // Counters hold "cycles remaining after this one", so a programmed 0 or 1 both load 0.
   function automatic logic [CW-1:0] load_val(input logic [CW-1:0] v);
      return (v == '0) ? '0 : v - CW'(1);
   endfunction

   function automatic logic [NW-1:0] clamp_num(input logic [NW-1:0] n);
      if (n == '0) return NW'(1);
      if (int'(n) > P) return NW'(P);
      return n;
   endfunction

   assign start   = (state_q == IDLE) && match_i && arm_i && trigger_enable_i;
   assign abort   = (state_q != IDLE) && !arm_i;
   assign idx_inc = idx_q + NW'(1);

   // Pulse-train state machine: next state, counters and registered outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      num_d     = num_q;
      dly_d     = dly_q;
      wid_d     = wid_q;
      trigger_d = trigger_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            trigger_d = 1'b0;
            cnt_d     = '0;
            if (start) begin
               dly_d = trigger_delay_i;
               wid_d = trigger_width_i;
               num_d = clamp_num(num_triggers_i);
               idx_d = '0;
               if (trigger_delay_i[CW-1:0] == '0) begin
                  // Zero first delay: the pulse starts on the very next cycle.
                  state_d   = PULSE;
                  trigger_d = 1'b1;
                  cnt_d     = load_val(trigger_width_i[CW-1:0]);
               end else begin
                  state_d = DELAY;
                  cnt_d   = trigger_delay_i[CW-1:0] - CW'(1);
               end
            end
         end
         DELAY: begin
            if (abort) begin
               state_d   = IDLE;
               trigger_d = 1'b0;
               cnt_d     = '0;
            end else if (cnt_q == '0) begin
               state_d   = PULSE;
               trigger_d = 1'b1;
               cnt_d     = load_val(pick(wid_q, idx_q));
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         PULSE: begin
            if (abort) begin
               state_d   = IDLE;
               trigger_d = 1'b0;
               cnt_d     = '0;
            end else if (cnt_q == '0) begin
               trigger_d = 1'b0;
               if (int'(idx_q) + 1 < int'(num_q)) begin
                  // Later delays count low time after the previous fall; 0 acts as 1.
                  state_d = DELAY;
                  idx_d   = idx_inc;
                  cnt_d   = load_val(pick(dly_q, idx_inc));
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            trigger_d = 1'b0;
         end
      endcase
      // Busy covers the whole train including the done strobe cycle.
      busy_d = (state_d != IDLE) || done_d;
   end

`ifdef PW_TRIG_CAPTURE_DELAY_EN
   localparam int DW = pCAPTURE_DELAY_WIDTH;
   logic [DW-1:0] cap_cnt_q, cap_cnt_d;
   logic          cap_act_q, cap_act_d;

   // Capture countdown runs beside the pulse train; an arm abort cancels it.
   always_comb begin
      cap_cnt_d = cap_cnt_q;
      cap_act_d = cap_act_q;
      cap_d     = 1'b0;
      if (abort) begin
         cap_act_d = 1'b0;
         cap_cnt_d = '0;
      end else if (start) begin
         if (capture_delay_i == '0) begin
            cap_d = 1'b1;
         end else begin
            cap_act_d = 1'b1;
            cap_cnt_d = capture_delay_i - DW'(1);
         end
      end else if (cap_act_q) begin
         if (cap_cnt_q == '0) begin
            cap_d     = 1'b1;
            cap_act_d = 1'b0;
         end else begin
            cap_cnt_d = cap_cnt_q - DW'(1);
         end
      end
   end

   // Capture countdown registers.
   always_ff @(posedge fe_clk) begin
      if (!reset_n) begin
         cap_cnt_q <= '0;
         cap_act_q <= 1'b0;
      end else begin
         cap_cnt_q <= cap_cnt_d;
         cap_act_q <= cap_act_d;
      end
   end
`else
   logic unused_capture_delay;
   assign unused_capture_delay = ^capture_delay_i;

   // Without the delay counter the capture pulse follows the accepted start.
   always_comb cap_d = start;
`endif

   // State, configuration and output registers.
   always_ff @(posedge fe_clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         num_q     <= '0;
         dly_q     <= '0;
         wid_q     <= '0;
         trigger_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         num_q     <= num_d;
         dly_q     <= dly_d;
         wid_q     <= wid_d;
         trigger_q <= trigger_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cap_q     <= cap_d;
      end
   end

   assign trigger_o              = trigger_q;
   assign capture_enable_pulse_o = cap_q;
   assign busy_o                 = busy_q;
   assign pulse_index_o          = idx_q;
   assign done_pulse_o           = done_q;
endmodule

// File: tb/tb_pw_trigger_seq.sv
// Scoreboard bench for pw_trigger_seq: each stimulus pushes hand-computed
// pulse/done/capture events; a negedge monitor pops and compares them.
module tb_pw_trigger_seq;
   localparam int P  = 8;
   localparam int NW = 4;
   localparam int CW = 24;
   localparam int DW = 18;
`ifdef PW_TRIG_CAPTURE_DELAY_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              arm_i, trigger_enable_i, match_i;
   logic [CW*P-1:0]   trigger_delay_i, trigger_width_i;
   logic [NW-1:0]     num_triggers_i;
   logic [DW-1:0]     capture_delay_i;
   logic              trigger_o, capture_enable_pulse_o, busy_o, done_pulse_o;
   logic [NW-1:0]     pulse_index_o;

   pw_trigger_seq #(
      .pNUM_TRIGGER_PULSES(P), .pNUM_TRIGGER_WIDTH(NW),
      .pTRIG_CNT_WIDTH(CW), .pCAPTURE_DELAY_WIDTH(DW)
   ) dut (
      .fe_clk(clk), .reset_n(reset_n), .arm_i(arm_i),
      .trigger_enable_i(trigger_enable_i), .match_i(match_i),
      .trigger_delay_i(trigger_delay_i), .trigger_width_i(trigger_width_i),
      .num_triggers_i(num_triggers_i), .capture_delay_i(capture_delay_i),
      .trigger_o(trigger_o), .capture_enable_pulse_o(capture_enable_pulse_o),
      .busy_o(busy_o), .pulse_index_o(pulse_index_o), .done_pulse_o(done_pulse_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int rise; int width; int idx; } trig_t;
   trig_t trig_exp[$];
   int    done_exp[$];
   int    cap_exp[$];
   int    tests = 0;
   int    fails = 0;
   int    rise_cyc = 0;
   int    rise_idx = 0;
   logic  prev_trig = 1'b0;

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) next();
   endtask

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end else begin
         $display("ok   %s = %0d (cycle %0d)", name, got, cyc);
      end
   endtask

   task automatic push_trig(input int rise, input int width, input int idx);
      trig_t e;
      e.rise = rise; e.width = width; e.idx = idx;
      trig_exp.push_back(e);
   endtask

   task automatic set_pulse(input int k, input int d, input int w);
      trigger_delay_i[k*CW +: CW] = CW'(d);
      trigger_width_i[k*CW +: CW] = CW'(w);
   endtask

   task automatic clear_cfg();
      trigger_delay_i = '0;
      trigger_width_i = '0;
      num_triggers_i  = '0;
      capture_delay_i = '0;
   endtask

   // Issue one match cycle; t returns the cycle in which match_i was high.
   task automatic do_match(output int t);
      match_i = 1'b1;
      t = cyc;
      next();
      match_i = 1'b0;
   endtask

   task automatic drained(input string name);
      int left;
      left = trig_exp.size() + done_exp.size() + cap_exp.size();
      chk({name, " events_left"}, left, 0);
      trig_exp.delete();
      done_exp.delete();
      cap_exp.delete();
   endtask

   // One monitor step per cycle, sampled on the falling edge.
   task automatic monitor_step();
      trig_t e;
      int    c;
      if (trigger_o && !prev_trig) begin
         rise_cyc = cyc;
         rise_idx = int'(pulse_index_o);
      end
      if (!trigger_o && prev_trig) begin
         tests++;
         if (trig_exp.size() == 0) begin
            fails++;
            $display("FAIL trig_unexpected: got rise=%0d width=%0d idx=%0d, expected no pulse",
                     rise_cyc, cyc - rise_cyc, rise_idx);
         end else begin
            e = trig_exp.pop_front();
            if (e.rise != rise_cyc || e.width != cyc - rise_cyc || e.idx != rise_idx) begin
               fails++;
               $display("FAIL trig_pulse: got rise=%0d width=%0d idx=%0d, expected rise=%0d width=%0d idx=%0d",
                        rise_cyc, cyc - rise_cyc, rise_idx, e.rise, e.width, e.idx);
            end else begin
               $display("ok   trig_pulse rise=%0d width=%0d idx=%0d", rise_cyc, cyc - rise_cyc, rise_idx);
            end
         end
      end
      prev_trig = trigger_o;
      if (done_pulse_o) begin
         tests++;
         if (done_exp.size() == 0) begin
            fails++;
            $display("FAIL done_unexpected: got done at %0d, expected none", cyc);
         end else begin
            c = done_exp.pop_front();
            if (c != cyc) begin
               fails++;
               $display("FAIL done_pulse: got cycle %0d, expected %0d", cyc, c);
            end else $display("ok   done_pulse cycle=%0d", cyc);
         end
      end
      if (capture_enable_pulse_o) begin
         tests++;
         if (cap_exp.size() == 0) begin
            fails++;
            $display("FAIL cap_unexpected: got capture at %0d, expected none", cyc);
         end else begin
            c = cap_exp.pop_front();
            if (c != cyc) begin
               fails++;
               $display("FAIL cap_pulse: got cycle %0d, expected %0d", cyc, c);
            end else $display("ok   cap_pulse cycle=%0d", cyc);
         end
      end
   endtask

   initial begin
      int t;
      reset_n = 1'b0; arm_i = 1'b1; trigger_enable_i = 1'b1; match_i = 1'b0;
      clear_cfg();
      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      // Reset state.
      idle(3);
      chk("rst trigger_o", int'(trigger_o), 0);
      chk("rst cap_o", int'(capture_enable_pulse_o), 0);
      chk("rst busy_o", int'(busy_o), 0);
      chk("rst done_o", int'(done_pulse_o), 0);
      chk("rst index_o", int'(pulse_index_o), 0);
      reset_n = 1'b1;
      idle(2);

      // Single minimal pulse: N=1, d0=0, w0=1, capture delay 0.
      clear_cfg(); num_triggers_i = 4'd1; set_pulse(0, 0, 1);
      do_match(t);
      push_trig(t + 1, 1, 0); done_exp.push_back(t + 2); cap_exp.push_back(t + 1);
      chk("single busy@T+1", int'(busy_o), 1);
      idle(6);
      drained("single");

      // Three-pulse train d={5,2,0}, w={3,1,4}, capture delay 4.
      clear_cfg(); num_triggers_i = 4'd3; capture_delay_i = 18'd4;
      set_pulse(0, 5, 3); set_pulse(1, 2, 1); set_pulse(2, 0, 4);
      do_match(t);
      push_trig(t + 6, 3, 0); push_trig(t + 11, 1, 1); push_trig(t + 13, 4, 2);
      done_exp.push_back(t + 17);
      cap_exp.push_back(CAP_EN ? t + 5 : t + 1);
      while (cyc < t + 17) next();
      chk("train3 busy@done", int'(busy_o), 1);
      next();
      chk("train3 busy@after", int'(busy_o), 0);
      idle(3);
      drained("train3");

      // Extra match during PULSE is ignored.
      clear_cfg(); num_triggers_i = 4'd2;
      set_pulse(0, 1, 4); set_pulse(1, 1, 2);
      do_match(t);
      push_trig(t + 2, 4, 0); push_trig(t + 7, 2, 1); done_exp.push_back(t + 9);
      cap_exp.push_back(t + 1);
      while (cyc < t + 3) next();
      match_i = 1'b1; next(); match_i = 1'b0;
      idle(12);
      drained("rematch");

      // num_triggers 0 acts as one pulse.
      clear_cfg(); num_triggers_i = 4'd0; capture_delay_i = 18'd2;
      set_pulse(0, 3, 2); set_pulse(1, 1, 1);
      do_match(t);
      push_trig(t + 4, 2, 0); done_exp.push_back(t + 6);
      cap_exp.push_back(CAP_EN ? t + 3 : t + 1);
      idle(10);
      drained("num0");

      // num_triggers 15 clamps to 8 pulses; zero delays/widths act as 1.
      clear_cfg(); num_triggers_i = 4'd15;
      do_match(t);
      for (int k = 0; k < P; k++) push_trig(t + 1 + 2 * k, 1, k);
      done_exp.push_back(t + 16); cap_exp.push_back(t + 1);
      idle(22);
      drained("num15");

      // Match with trigger_enable low starts nothing.
      clear_cfg(); num_triggers_i = 4'd1; trigger_enable_i = 1'b0;
      do_match(t);
      idle(2);
      chk("noenable busy", int'(busy_o), 0);
      idle(8);
      drained("noenable");
      trigger_enable_i = 1'b1;

      // Arm dropped mid-pulse aborts the train and any pending capture.
      clear_cfg(); num_triggers_i = 4'd2; capture_delay_i = 18'd100;
      set_pulse(0, 5, 3); set_pulse(1, 2, 1);
      do_match(t);
      push_trig(t + 6, 2, 0);
      if (!CAP_EN) cap_exp.push_back(t + 1);
      while (cyc < t + 7) next();
      arm_i = 1'b0;
      next();
      chk("abort trigger@8", int'(trigger_o), 0);
      chk("abort busy@8", int'(busy_o), 0);
      while (cyc < t + 115) next();
      drained("abort");
      arm_i = 1'b1;
      idle(2);

      // Reset in the middle of the second pulse, then a fresh start.
      clear_cfg(); num_triggers_i = 4'd2;
      set_pulse(0, 0, 1); set_pulse(1, 0, 10);
      do_match(t);
      push_trig(t + 1, 1, 0); push_trig(t + 3, 4, 1); cap_exp.push_back(t + 1);
      while (cyc < t + 6) next();
      chk("midreset index", int'(pulse_index_o), 1);
      reset_n = 1'b0;
      next();
      chk("reset trigger_o", int'(trigger_o), 0);
      chk("reset busy_o", int'(busy_o), 0);
      chk("reset index_o", int'(pulse_index_o), 0);
      chk("reset done_o", int'(done_pulse_o), 0);
      reset_n = 1'b1;
      idle(2);
      drained("midreset");
      clear_cfg(); num_triggers_i = 4'd1; capture_delay_i = 18'd3;
      set_pulse(0, 2, 2);
      do_match(t);
      push_trig(t + 3, 2, 0); done_exp.push_back(t + 5);
      cap_exp.push_back(CAP_EN ? t + 4 : t + 1);
      idle(8);
      drained("afterreset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
